// File: rtl/bcd_display_formatter.sv
// Converts each newly shown 16-bit value to five packed BCD digits with a serial
// double-dabble engine (16 cycles). Optional feature macro: LEADING_ZERO_BLANK_EN.
module bcd_display_formatter (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] data_in,
   input  logic        show_input,
   output logic [19:0] bcd_out,
   output logic        valid_out,
   output logic        update,
   output logic        busy
);

   typedef enum logic {IDLE, CONV} state_t;

   state_t      state, state_next;
   logic [15:0] last_value;
   logic        have_value;
   logic [35:0] sr, sr_next;
   logic [4:0]  cnt;
   logic        start, done;

   assign start = (state == IDLE) && show_input && (!have_value || (data_in != last_value));
   assign done  = (state == CONV) && (cnt == 5'd15);

   // Leading-zero blanking replaces zero digits above the first non-zero one with 4'hF.
   function automatic logic [19:0] format_digits(input logic [19:0] bcd);
      logic [19:0] result;
      result = bcd;
`ifdef LEADING_ZERO_BLANK_EN
      for (int i = 4; i >= 1; i--) begin
         if (result[4*i +: 4] != 4'h0) break;
         result[4*i +: 4] = 4'hF;
      end
`endif
      return result;
   endfunction

   // One double-dabble step: add 3 to each digit >= 5, then shift left.
   always_comb begin
      // NOTE: default assignment first so every path writes sr_next and no latch is inferred.
      sr_next = sr;
      for (int i = 0; i < 5; i++) begin
         if (sr_next[16 + 4*i +: 4] >= 4'd5)
            sr_next[16 + 4*i +: 4] = sr_next[16 + 4*i +: 4] + 4'd3;
      end
      sr_next = {sr_next[34:0], 1'b0};
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = CONV;
         CONV:    if (done)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == CONV);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: sr and cnt are pure datapath, always reloaded on start, so they carry no reset.
         last_value <= 16'h0000;
         have_value <= 1'b0;
         bcd_out    <= 20'h00000;
         valid_out  <= 1'b0;
         update     <= 1'b0;
      end else begin
         update <= 1'b0;
         if (start) begin
            last_value <= data_in;
            have_value <= 1'b1;
         end
         if (done) begin
            bcd_out   <= format_digits(sr_next[35:16]);
            valid_out <= 1'b1;
            update    <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         sr  <= {20'h00000, data_in};
         cnt <= 5'd0;
      end else if (state == CONV) begin
         sr  <= sr_next;
         cnt <= cnt + 5'd1;
      end
   end

endmodule
